// File: rtl/bus_slave_mem.sv
// bus_slave_mem
//   Memory-mapped target terminating the slave side of the bus bridge.
//   Serves reads and byte-strobed writes from an internal word-addressed
//   RAM, one transaction at a time, with a programmable response delay.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   s_req_*          request channel (valid/addr/write/id in, ready out)
//   s_data_*         write data channel (valid/data/strb in, ready out)
//   s_resp_*         response channel (valid/data/id/error out, ready in)
//
// Optional feature
//   BUS_SLAVE_MEM_ALIGN_CHK_EN : when defined, a request whose address is not
//   word-aligned is answered with an error (writes still consume their beat).
//
// State table
//   ST_IDLE  | waiting for a request; request channel ready
//   ST_WDATA | write accepted, waiting for its data beat
//   ST_WAIT  | counting out the response delay
//   ST_RESP  | response presented until consumed

module bus_slave_mem #(
  parameter int unsigned              ADDR_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH = 32,
  parameter int unsigned              ID_WIDTH   = 4,
  parameter int unsigned              DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned              RESP_DELAY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]   s_req_addr_i,
  input  logic                    s_req_write_i,
  input  logic [ID_WIDTH-1:0]     s_req_id_i,
  output logic                    s_req_ready_o,
  input  logic                    s_data_valid_i,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic [DATA_WIDTH/8-1:0] s_data_strb_i,
  output logic                    s_data_ready_o,
  output logic                    s_resp_valid_o,
  output logic [DATA_WIDTH-1:0]   s_resp_data_o,
  output logic [ID_WIDTH-1:0]     s_resp_id_o,
  output logic                    s_resp_error_o,
  input  logic                    s_resp_ready_i
);

  localparam int unsigned LP_STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LP_BYTE_W = $clog2(LP_STRB_W);
  localparam int unsigned LP_IDX_W  = $clog2(DEPTH);
  localparam int unsigned LP_SPAN   = DEPTH * LP_STRB_W;
  localparam bit          LP_NO_DLY = (RESP_DELAY == 0);

  // One extra bit so BASE_ADDR + span cannot wrap at the top of the map.
  localparam logic [ADDR_WIDTH:0] LP_BASE = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] LP_END  = LP_BASE + (ADDR_WIDTH+1)'(LP_SPAN);

  typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_WAIT, ST_RESP} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_req_rdy;
  logic                    r_data_rdy;
  logic [3:0]              r_cnt;
  logic [ID_WIDTH-1:0]     r_id;
  logic                    r_err;
  logic [LP_IDX_W-1:0]     r_idx;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic [ADDR_WIDTH:0]     w_addr_x;
  logic [ADDR_WIDTH-1:0]   w_off;
  logic [LP_IDX_W-1:0]     w_idx;
  logic                    w_range_err;
  logic                    w_misalign;
  logic                    w_err;
  logic                    w_req_hs;
  logic                    w_data_hs;
  logic                    w_wr_en;
  logic                    w_enter_wait;

  // ---------------------------------------------------------------- decode
  assign w_addr_x    = {1'b0, s_req_addr_i};
  assign w_range_err = (w_addr_x < LP_BASE) || (w_addr_x >= LP_END);
  assign w_off       = s_req_addr_i - BASE_ADDR;
  assign w_idx       = LP_IDX_W'(w_off >> LP_BYTE_W);

`ifdef BUS_SLAVE_MEM_ALIGN_CHK_EN
  assign w_misalign  = |s_req_addr_i[LP_BYTE_W-1:0];
`else
  assign w_misalign  = 1'b0;
`endif

  assign w_err       = w_range_err || w_misalign;

  // Handshakes qualify on the registered ready, which is only set in the
  // matching state, so inputs are ignored everywhere else.
  assign w_req_hs    = s_req_valid_i  && r_req_rdy;
  assign w_data_hs   = s_data_valid_i && r_data_rdy;
  // A beat arriving on a reset edge is dropped with the abandoned write.
  assign w_wr_en     = w_data_hs && !r_err && rst_n;

  // ------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req_hs) begin
          if (s_req_write_i) w_next = ST_WDATA;
          else               w_next = LP_NO_DLY ? ST_RESP : ST_WAIT;
        end
      end
      ST_WDATA: begin
        if (w_data_hs) w_next = LP_NO_DLY ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt <= 4'd1) w_next = ST_RESP;
      end
      ST_RESP: begin
        if (s_resp_ready_i) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------- outputs
  always_comb begin
    s_req_ready_o  = r_req_rdy;
    s_data_ready_o = r_data_rdy;
    s_resp_valid_o = (r_state == ST_RESP);
    s_resp_data_o  = r_rdata;
    s_resp_id_o    = r_id;
    s_resp_error_o = r_err;
  end

  // Ready flags are registered copies of "next state is X" so they are low
  // while reset is held and carry no path from inputs to outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_rdy  <= 1'b0;
      r_data_rdy <= 1'b0;
    end else begin
      r_req_rdy  <= (w_next == ST_IDLE);
      r_data_rdy <= (w_next == ST_WDATA);
    end
  end

  // ------------------------------------------------------ response delay
  assign w_enter_wait = (r_state != ST_WAIT) && (w_next == ST_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (w_enter_wait) begin
      r_cnt <= 4'(RESP_DELAY);
    end else if (r_state == ST_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // ---------------------------------------------------- request capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_id    <= '0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_rdata <= '0;
    end else if (w_req_hs) begin
      r_id    <= s_req_id_i;
      r_err   <= w_err;
      r_idx   <= w_idx;
      r_rdata <= (s_req_write_i || w_err) ? '0 : r_mem[w_idx];
    end
  end

  // ------------------------------------------------------------------ RAM
  // Not reset: contents persist across rst_n.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < int'(LP_STRB_W); i++) begin
        if (s_data_strb_i[i]) r_mem[r_idx][8*i +: 8] <= s_data_i[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bus_slave_mem.sv
module tb_bus_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_write;
  logic [3:0]  req_id;
  logic        req_ready;
  logic        data_valid;
  logic [31:0] data;
  logic [3:0]  strb;
  logic        data_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [3:0]  resp_id;
  logic        resp_error;
  logic        resp_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_slave_mem dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_req_valid_i  (req_valid),
    .s_req_addr_i   (req_addr),
    .s_req_write_i  (req_write),
    .s_req_id_i     (req_id),
    .s_req_ready_o  (req_ready),
    .s_data_valid_i (data_valid),
    .s_data_i       (data),
    .s_data_strb_i  (strb),
    .s_data_ready_o (data_ready),
    .s_resp_valid_o (resp_valid),
    .s_resp_data_o  (resp_data),
    .s_resp_id_o    (resp_id),
    .s_resp_error_o (resp_error),
    .s_resp_ready_i (resp_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic w, input logic [3:0] id);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_write = w; req_id = id;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", {31'b0, n < 50}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_data(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    data_valid = 1'b1; data = d; strb = s;
    while (!data_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("data_accept", {31'b0, n < 50}, 32'd1);
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  // Called just after a handshake edge; returns the cycle in which valid
  // was first seen, counting the cycle after the handshake as 1.
  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 50);
  endtask

  task automatic accept_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic txn_read(input logic [31:0] a, input logic [3:0] id,
                          input logic [31:0] exp_d, input logic exp_e);
    int lat;
    do_req(a, 1'b0, id);
    wait_resp(lat);
    chk("rd_latency", lat, 32'd3);
    chk("rd_data", resp_data, exp_d);
    chk("rd_id", {28'b0, resp_id}, {28'b0, id});
    chk("rd_err", {31'b0, resp_error}, {31'b0, exp_e});
    accept_resp();
  endtask

  task automatic txn_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [3:0] id, input logic exp_e);
    int lat;
    do_req(a, 1'b1, id);
    do_data(d, s);
    wait_resp(lat);
    chk("wr_latency", lat, 32'd3);
    chk("wr_data", resp_data, 32'd0);
    chk("wr_id", {28'b0, resp_id}, {28'b0, id});
    chk("wr_err", {31'b0, resp_error}, {31'b0, exp_e});
    accept_resp();
  endtask

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_id = '0;
    data_valid = 1'b0; data = '0; strb = '0; resp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_data_ready", {31'b0, data_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_id", {28'b0, resp_id}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_error}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rel_data_ready", {31'b0, data_ready}, 32'd0);

    // Full-word write then read back
    txn_write(32'h10, 32'h8765_4321, 4'hF, 4'd2, 1'b0);
    txn_read (32'h10, 4'd1, 32'h8765_4321, 1'b0);

    // Byte-strobe merge
    txn_write(32'h20, 32'hDEAD_BEEF, 4'hF, 4'd3, 1'b0);
    txn_write(32'h20, 32'h0000_00AA, 4'h1, 4'd4, 1'b0);
    txn_read (32'h20, 4'd5, 32'hDEAD_BEAA, 1'b0);

    // Range boundaries: last word is valid, one past it errors and an
    // out-of-range write (whose truncated index would be word 0) is dropped
    txn_write(32'h0, 32'h5A5A_0F0F, 4'hF, 4'd6, 1'b0);
    txn_write(32'h3FC, 32'h0BAD_F00D, 4'hF, 4'd7, 1'b0);
    txn_read (32'h3FC, 4'd8, 32'h0BAD_F00D, 1'b0);
    txn_read (32'h400, 4'd9, 32'h0, 1'b1);
    txn_write(32'h400, 32'hFFFF_FFFF, 4'hF, 4'd10, 1'b1);
    txn_read (32'h0, 4'd11, 32'h5A5A_0F0F, 1'b0);

    // Response backpressure holds everything stable
    do_req(32'h10, 1'b0, 4'd12);
    wait_resp(lat);
    chk("bp_latency", lat, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_data", resp_data, 32'h8765_4321);
      chk("bp_id", {28'b0, resp_id}, 32'd12);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    accept_resp();

    // Reset while a write waits for its data beat
    txn_write(32'h30, 32'h1122_3344, 4'hF, 4'd13, 1'b0);
    do_req(32'h30, 1'b1, 4'd14);
    @(negedge clk);
    chk("wd_data_ready", {31'b0, data_ready}, 32'd1);
    chk("wd_req_ready", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("mid_rst_data_ready", {31'b0, data_ready}, 32'd0);
    chk("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("mid_rst_resp_id", {28'b0, resp_id}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    @(negedge clk);
    chk("mid_rel_req_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    chk("mid_rel_no_resp", seen, 32'd0);
    txn_read(32'h30, 4'd15, 32'h1122_3344, 1'b0);

    // Misaligned write
`ifdef BUS_SLAVE_MEM_ALIGN_CHK_EN
    txn_write(32'h13, 32'hCAFE_F00D, 4'hF, 4'd3, 1'b1);
    txn_read (32'h10, 4'd4, 32'h8765_4321, 1'b0);
`else
    txn_write(32'h13, 32'hCAFE_F00D, 4'hF, 4'd3, 1'b0);
    txn_read (32'h10, 4'd4, 32'hCAFE_F00D, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
